returns_sequencer: RTL and testbench
====================================

# returns_sequencer

Controller that turns a stream of 4-asset price snapshots into per-asset return vectors. It sequences the shared `vector_division` unit: it keeps the previous snapshot and issues one division per new tick (a = previous, b = new). It captures the result and presents it downstream with a valid/ready handshake. It sits between the market-data tick decoder and the covariance stack.

## Interface
- `N_ASSETS`, default 4: vector length.
- `WIDTH`, default 16: signed element width.
- `DIV_TIMEOUT`, default 64: max cycles waiting for `div_ready` before abort.

Ports:
- `clk_100mhz` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `cfg_sel` in 1: divider mode, latched at issue, driven on `div_sel`.
- `tick_valid` in 1: new price snapshot offered.
- `tick_ready` out 1: sequencer accepts a snapshot this cycle.
- `tick_price` in [0:N_ASSETS-1] x WIDTH signed: snapshot.
- `div_valid` out 1: one-cycle start pulse to the divider.
- `div_a` out [0:N_ASSETS-1] x WIDTH signed: previous prices.
- `div_b` out [0:N_ASSETS-1] x WIDTH signed: new prices.
- `div_sel` out 1: latched `cfg_sel`.
- `div_ready` in 1: one-cycle done pulse; `div_c` is valid in that cycle.
- `div_c` in [0:N_ASSETS-1] x WIDTH signed: divider result.
- `ret_valid` out 1: return vector available.
- `ret_ready` in 1: downstream accepts.
- `ret_data` out [0:N_ASSETS-1] x WIDTH signed: returns.
- `err_timeout` out 1: sticky, set on divider timeout.
- `skip_count` out 16: ticks dropped because a previous price was zero; saturating.

## Operation
- States:
  - EMPTY: no previous snapshot.
  - PRIMED: previous snapshot held.
  - ISSUE
  - WAIT
  - OUT
- `tick_ready` = 1 only in EMPTY and PRIMED. A tick is accepted when `tick_valid && tick_ready`.
- EMPTY + accept: `prev <= tick_price`, go to PRIMED. No division, no output.
- PRIMED + accept:
  - If any `prev` element is 0: `prev <= tick_price`, `skip_count++` (saturate at 0xFFFF), stay in PRIMED.
  - Else: `next <= tick_price`, `sel_q <= cfg_sel`, go to ISSUE.
- ISSUE:
  - `div_valid` = 1 for exactly one cycle.
  - `div_a` = `prev`, `div_b` = `next`, `div_sel` = `sel_q`.
  - Go to WAIT and clear the timeout counter.
- `div_a`, `div_b` and `div_sel` hold stable from ISSUE through the end of WAIT.
- WAIT:
  - `div_ready` = 1: `ret_data <= div_c`, `prev <= next`, go to OUT.
  - Otherwise, when the counter reaches `DIV_TIMEOUT`-1: `err_timeout <= 1`, `prev <= next`, go to PRIMED. The result is discarded.
- A `div_ready` pulse outside WAIT is ignored.
- OUT: `ret_valid` = 1 and `ret_data` is held stable until `ret_ready`. On handshake, go to PRIMED.
- Only `reset` clears `err_timeout`.
- No arithmetic in this block; all element widths pass through at `WIDTH`.

## Timing
- Reset values:
  - state EMPTY
  - `tick_ready` 1
  - `div_valid` 0
  - `ret_valid` 0
  - `err_timeout` 0
  - `skip_count` 0
  - `div_a`, `div_b`, `ret_data` all zero
  - `div_sel` 0
- Reset in any state returns to EMPTY next cycle. The previous snapshot is lost, and any in-flight divider result is ignored.
- With tick accepted at cycle T and divider latency L (`div_ready` at T+1+L):
  - `div_valid` at T+1.
  - `ret_valid` at T+2+L.
  - `tick_ready` returns at T+3+L if `ret_ready` is already 1.
- Minimum L is 1, so `div_ready` can arrive in the cycle after ISSUE.
- `ret_valid` is registered. `tick_ready` is a decode of registered state only, with no combinational path from `ret_ready`.

## Structure
- Shared package `hft_pkg` holds:
  - `N_ASSETS`
  - `WIDTH`
  - `typedef logic signed [WIDTH-1:0] price_t`
  - `typedef price_t price_vec_t [0:N_ASSETS-1]`
  - `typedef enum {EMPTY, PRIMED, ISSUE, WAIT, OUT} seq_state_t`
- Single module with no sub-module. `vector_division` is instantiated alongside it by the parent, not inside it.

## Test plan
- Reset, then tick {100,200,300,400}:
  - No `div_valid`, state PRIMED, `ret_valid` stays 0.
- Then tick {110,210,310,410}, `cfg_sel`=1, divider model with L=3 returns {1,2,3,4}:
  - `div_valid` one cycle with a={100,200,300,400}, b={110,210,310,410}, `div_sel`=1.
  - `ret_valid` at T+5 with `ret_data`={1,2,3,4}.
- Hold `ret_ready`=0 for 10 cycles:
  - `ret_data` stable, `tick_ready`=0 throughout, and extra `tick_valid` is not accepted.
- Prime with {0,200,300,400}, then tick {110,210,310,410}:
  - No `div_valid`, `skip_count`=1.
  - Next tick issues with a={110,210,310,410}.
- Divider never asserts `div_ready`:
  - `err_timeout`=1 after 64 WAIT cycles, state PRIMED.
  - The next tick divides against the timed-out snapshot.
- Assert `reset` during WAIT, then pulse `div_ready`:
  - `ret_valid` stays 0, state EMPTY.
  - The first post-reset tick only primes.

Source files
------------

// File: rtl/hft_pkg.sv
// Shared types for the market-data datapath: price vectors and the returns sequencer states.
package hft_pkg;

    localparam int unsigned N_ASSETS = 4;
    localparam int unsigned WIDTH    = 16;

    typedef logic signed [WIDTH-1:0] price_t;
    typedef price_t price_vec_t [0:N_ASSETS-1];

    typedef enum logic [2:0] {EMPTY, PRIMED, ISSUE, WAIT, OUT} seq_state_t;

endpackage

// File: rtl/returns_sequencer.sv
// Sequences the shared vector divider to turn consecutive price snapshots into return vectors,
// holding the previous snapshot and presenting each result on a valid/ready port.
module returns_sequencer
    import hft_pkg::*;
#(
    parameter int unsigned N_ASSETS    = hft_pkg::N_ASSETS,
    parameter int unsigned WIDTH       = hft_pkg::WIDTH,
    parameter int unsigned DIV_TIMEOUT = 64
) (
    input  logic                    clk_100mhz,
    input  logic                    reset,
    input  logic                    cfg_sel,
    input  logic                    tick_valid,
    output logic                    tick_ready,
    input  logic signed [WIDTH-1:0] tick_price [0:N_ASSETS-1],
    output logic                    div_valid,
    output logic signed [WIDTH-1:0] div_a [0:N_ASSETS-1],
    output logic signed [WIDTH-1:0] div_b [0:N_ASSETS-1],
    output logic                    div_sel,
    input  logic                    div_ready,
    input  logic signed [WIDTH-1:0] div_c [0:N_ASSETS-1],
    output logic                    ret_valid,
    input  logic                    ret_ready,
    output logic signed [WIDTH-1:0] ret_data [0:N_ASSETS-1],
    output logic                    err_timeout,
    output logic [15:0]             skip_count
);

    localparam int unsigned CW = (DIV_TIMEOUT > 2) ? $clog2(DIV_TIMEOUT) : 1;
    localparam logic [CW-1:0] TLAST = CW'(DIV_TIMEOUT - 1);

    seq_state_t              state;
    logic signed [WIDTH-1:0] prev [0:N_ASSETS-1];
    logic signed [WIDTH-1:0] next [0:N_ASSETS-1];
    logic                    sel_q;
    logic [CW-1:0]           tcnt;
    logic                    prev_has_zero;

    // A zero previous price would make the return undefined, so such ticks only re-prime.
    always_comb begin
        prev_has_zero = 1'b0;
        for (int i = 0; i < int'(N_ASSETS); i++) begin
            if (prev[i] == '0) begin
                prev_has_zero = 1'b1;
            end
        end
    end

    // prev and next are untouched from ISSUE until WAIT exits, so the operands stay stable.
    assign div_a   = prev;
    assign div_b   = next;
    assign div_sel = sel_q;

    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            state       <= EMPTY;
            prev        <= '{default: '0};
            next        <= '{default: '0};
            ret_data    <= '{default: '0};
            sel_q       <= 1'b0;
            tcnt        <= '0;
            tick_ready  <= 1'b1;
            div_valid   <= 1'b0;
            ret_valid   <= 1'b0;
            err_timeout <= 1'b0;
            skip_count  <= '0;
        end else begin
            div_valid <= 1'b0;
            unique case (state)
                EMPTY: begin
                    if (tick_valid) begin
                        prev  <= tick_price;
                        state <= PRIMED;
                    end
                end
                PRIMED: begin
                    if (tick_valid) begin
                        if (prev_has_zero) begin
                            prev <= tick_price;
                            if (skip_count != 16'hFFFF) begin
                                skip_count <= skip_count + 16'd1;
                            end
                        end else begin
                            next       <= tick_price;
                            sel_q      <= cfg_sel;
                            div_valid  <= 1'b1;
                            tick_ready <= 1'b0;
                            state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    tcnt  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (div_ready) begin
                        ret_data  <= div_c;
                        prev      <= next;
                        ret_valid <= 1'b1;
                        state     <= OUT;
                    end else if (tcnt == TLAST) begin
                        // Abandon the division but keep the new snapshot as the next baseline.
                        err_timeout <= 1'b1;
                        prev        <= next;
                        tick_ready  <= 1'b1;
                        state       <= PRIMED;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                OUT: begin
                    if (ret_ready) begin
                        ret_valid  <= 1'b0;
                        tick_ready <= 1'b1;
                        state      <= PRIMED;
                    end
                end
                default: begin
                    tick_ready <= 1'b1;
                    ret_valid  <= 1'b0;
                    state      <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_returns_sequencer.sv
// Self-checking bench for returns_sequencer: directed table, hand-written corner sequences and
// a randomized run against a transaction-level model.
module tb_returns_sequencer;
    import hft_pkg::*;

    localparam int TMO = 64;

    typedef logic [63:0] v64_t;

    typedef struct {
        v64_t price;
        logic sel;
        int   lat;
        v64_t c;
        bit   issue;
        v64_t exp_a;
        int   exp_skip;
    } rec_t;

    logic        clk_100mhz = 1'b0;
    logic        reset      = 1'b1;
    logic        cfg_sel    = 1'b0;
    logic        tick_valid = 1'b0;
    logic        tick_ready;
    logic        div_valid;
    logic        div_sel;
    logic        div_ready  = 1'b0;
    logic        ret_valid;
    logic        ret_ready  = 1'b1;
    logic        err_timeout;
    logic [15:0] skip_count;
    price_vec_t  tick_price;
    price_vec_t  div_a;
    price_vec_t  div_b;
    price_vec_t  div_c;
    price_vec_t  ret_data;

    int errors = 0;
    int checks = 0;

    returns_sequencer #(
        .N_ASSETS    (4),
        .WIDTH       (16),
        .DIV_TIMEOUT (TMO)
    ) dut (
        .clk_100mhz  (clk_100mhz),
        .reset       (reset),
        .cfg_sel     (cfg_sel),
        .tick_valid  (tick_valid),
        .tick_ready  (tick_ready),
        .tick_price  (tick_price),
        .div_valid   (div_valid),
        .div_a       (div_a),
        .div_b       (div_b),
        .div_sel     (div_sel),
        .div_ready   (div_ready),
        .div_c       (div_c),
        .ret_valid   (ret_valid),
        .ret_ready   (ret_ready),
        .ret_data    (ret_data),
        .err_timeout (err_timeout),
        .skip_count  (skip_count)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    function automatic v64_t pk(input price_vec_t v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    function automatic v64_t mk(input int a, input int b, input int c, input int d);
        return {16'(a), 16'(b), 16'(c), 16'(d)};
    endfunction

    function automatic bit has_zero(input v64_t v);
        for (int i = 0; i < 4; i++) begin
            if (v[16*i +: 16] == 16'd0) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic v64_t rand_vec();
        v64_t v;
        for (int i = 0; i < 4; i++) begin
            v[16*i +: 16] = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom);
        end
        return v;
    endfunction

    task automatic set_tick(input v64_t v);
        for (int i = 0; i < 4; i++) tick_price[i] = v[63-16*i -: 16];
    endtask

    task automatic set_c(input v64_t v);
        for (int i = 0; i < 4; i++) div_c[i] = v[63-16*i -: 16];
    endtask

    task automatic chk(input string name, input v64_t act, input v64_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk_100mhz);
    endtask

    // Offer one tick, then play the divider with the given latency and drain the result.
    task automatic run_tick(input string tag, input v64_t price, input logic sel, input int lat,
                            input v64_t c, input bit issue, input v64_t exp_a, input int exp_skip);
        tick_valid = 1'b1;
        cfg_sel    = sel;
        set_tick(price);
        cyc();
        tick_valid = 1'b0;
        chk({tag, " div_valid"}, div_valid, issue);
        if (issue) begin
            chk({tag, " div_a"}, pk(div_a), exp_a);
            chk({tag, " div_b"}, pk(div_b), price);
            chk({tag, " div_sel"}, div_sel, sel);
            chk({tag, " tick_ready busy"}, tick_ready, 0);
            for (int i = 0; i < lat; i++) begin
                cyc();
                chk({tag, " wait ret_valid"}, ret_valid, 0);
                chk({tag, " wait div_valid"}, div_valid, 0);
                chk({tag, " wait div_a"}, pk(div_a), exp_a);
            end
            div_ready = 1'b1;
            set_c(c);
            cyc();
            div_ready = 1'b0;
            set_c(64'd0);
            chk({tag, " ret_valid"}, ret_valid, 1);
            chk({tag, " ret_data"}, pk(ret_data), c);
            chk({tag, " out tick_ready"}, tick_ready, 0);
            cyc();
            chk({tag, " drained ret_valid"}, ret_valid, 0);
            chk({tag, " drained tick_ready"}, tick_ready, 1);
        end else begin
            chk({tag, " tick_ready"}, tick_ready, 1);
            chk({tag, " skip_count"}, skip_count, exp_skip);
        end
    endtask

    rec_t tbl [9];

    // Random-run model state.
    bit   m_have;
    v64_t m_prev, m_pend, m_c, e_a, e_b;
    logic e_sel;
    int   m_skip;
    bit   m_err;
    int   phase;
    int   n, resp;
    v64_t rp;

    initial begin
        tbl[0] = '{mk(100, 200, 300, 400), 1'b0, 0, 64'd0, 1'b0, 64'd0, 0};
        tbl[1] = '{mk(110, 210, 310, 410), 1'b1, 3, mk(1, 2, 3, 4), 1'b1,
                   mk(100, 200, 300, 400), 0};
        tbl[2] = '{mk(0, 200, 300, 400), 1'b0, 1, mk(5, 6, 7, 8), 1'b1,
                   mk(110, 210, 310, 410), 0};
        tbl[3] = '{mk(110, 210, 310, 410), 1'b0, 0, 64'd0, 1'b0, 64'd0, 1};
        tbl[4] = '{mk(120, 220, 320, 420), 1'b0, 1, mk(-1, -2, -3, -4), 1'b1,
                   mk(110, 210, 310, 410), 1};
        tbl[5] = '{mk(-5, 7, -9, 11), 1'b1, 2, mk(9, 9, 9, 9), 1'b1,
                   mk(120, 220, 320, 420), 1};
        tbl[6] = '{mk(0, 0, 0, 0), 1'b0, 1, mk(0, 1, 0, 1), 1'b1, mk(-5, 7, -9, 11), 1};
        tbl[7] = '{mk(1, 1, 1, 1), 1'b0, 0, 64'd0, 1'b0, 64'd0, 2};
        tbl[8] = '{mk(2, 2, 2, 2), 1'b1, 4, mk(3, 3, 3, 3), 1'b1, mk(1, 1, 1, 1), 2};

        set_tick(64'd0);
        set_c(64'd0);
        repeat (2) cyc();
        reset = 1'b0;
        cyc();
        chk("reset tick_ready", tick_ready, 1);
        chk("reset div_valid", div_valid, 0);
        chk("reset ret_valid", ret_valid, 0);
        chk("reset err_timeout", err_timeout, 0);
        chk("reset skip_count", skip_count, 0);
        chk("reset div_a", pk(div_a), 0);
        chk("reset div_b", pk(div_b), 0);
        chk("reset ret_data", pk(ret_data), 0);
        chk("reset div_sel", div_sel, 0);

        for (int i = 0; i < 9; i++) begin
            run_tick($sformatf("tbl%0d", i), tbl[i].price, tbl[i].sel, tbl[i].lat, tbl[i].c,
                     tbl[i].issue, tbl[i].exp_a, tbl[i].exp_skip);
        end

        // Back-pressure: result held while ret_ready is low, extra ticks refused.
        ret_ready  = 1'b0;
        tick_valid = 1'b1;
        cfg_sel    = 1'b0;
        set_tick(mk(50, 60, 70, 80));
        cyc();
        tick_valid = 1'b0;
        chk("hold div_valid", div_valid, 1);
        cyc();
        div_ready = 1'b1;
        set_c(mk(11, 22, 33, 44));
        cyc();
        div_ready = 1'b0;
        set_c(64'd0);
        chk("hold ret_valid", ret_valid, 1);
        for (int i = 0; i < 10; i++) begin
            tick_valid = 1'b1;
            set_tick(mk(77, 77, 77, 77));
            cyc();
            chk("hold ret_valid", ret_valid, 1);
            chk("hold ret_data", pk(ret_data), mk(11, 22, 33, 44));
            chk("hold tick_ready", tick_ready, 0);
        end
        tick_valid = 1'b0;
        ret_ready  = 1'b1;
        cyc();
        chk("hold release ret_valid", ret_valid, 0);
        chk("hold release tick_ready", tick_ready, 1);
        run_tick("after hold", mk(90, 90, 90, 90), 1'b0, 1, mk(4, 4, 4, 4), 1'b1,
                 mk(50, 60, 70, 80), 2);

        // Divider never answers.
        tick_valid = 1'b1;
        set_tick(mk(3, 4, 5, 6));
        cyc();
        tick_valid = 1'b0;
        chk("tmo div_valid", div_valid, 1);
        for (int i = 1; i <= TMO; i++) begin
            cyc();
            chk($sformatf("tmo wait%0d tick_ready", i), tick_ready, 0);
            chk($sformatf("tmo wait%0d err", i), err_timeout, 0);
        end
        cyc();
        chk("tmo tick_ready", tick_ready, 1);
        chk("tmo err_timeout", err_timeout, 1);
        chk("tmo ret_valid", ret_valid, 0);
        run_tick("after tmo", mk(7, 8, 9, 10), 1'b1, 2, mk(6, 5, 4, 3), 1'b1, mk(3, 4, 5, 6), 2);
        chk("tmo sticky", err_timeout, 1);

        // Reset while waiting on the divider.
        tick_valid = 1'b1;
        set_tick(mk(20, 20, 20, 20));
        cyc();
        tick_valid = 1'b0;
        chk("rst div_valid", div_valid, 1);
        cyc();
        reset = 1'b1;
        cyc();
        reset     = 1'b0;
        div_ready = 1'b1;
        set_c(mk(9, 9, 9, 9));
        cyc();
        div_ready = 1'b0;
        set_c(64'd0);
        chk("rst ret_valid", ret_valid, 0);
        chk("rst tick_ready", tick_ready, 1);
        chk("rst err_timeout", err_timeout, 0);
        chk("rst skip_count", skip_count, 0);
        chk("rst div_a", pk(div_a), 0);
        cyc();
        chk("rst ret_valid later", ret_valid, 0);
        run_tick("rst prime", mk(30, 30, 30, 30), 1'b0, 0, 64'd0, 1'b0, 64'd0, 0);
        run_tick("rst first", mk(40, 40, 40, 40), 1'b0, 1, mk(1, 1, 1, 1), 1'b1,
                 mk(30, 30, 30, 30), 0);

        // Randomized run against the transaction model.
        reset = 1'b1;
        cyc();
        reset  = 1'b0;
        m_have = 1'b0;
        m_skip = 0;
        m_err  = 1'b0;
        phase  = 0;
        for (int cy = 0; cy < 1500; cy++) begin
            cyc();
            chk("rnd tick_ready", tick_ready, phase == 0);
            chk("rnd div_valid", div_valid, phase == 1);
            chk("rnd ret_valid", ret_valid, phase == 3);
            chk("rnd err_timeout", err_timeout, m_err);
            chk("rnd skip_count", skip_count, m_skip);
            if (phase == 1 || phase == 2) begin
                chk("rnd div_a", pk(div_a), e_a);
                chk("rnd div_b", pk(div_b), e_b);
                chk("rnd div_sel", div_sel, e_sel);
            end
            if (phase == 3) chk("rnd ret_data", pk(ret_data), m_c);

            tick_valid = 1'b0;
            div_ready  = 1'b0;
            ret_ready  = 1'b0;
            cfg_sel    = 1'($urandom);
            if ($urandom_range(0, 2) != 0) begin
                tick_valid = 1'b1;
                rp = rand_vec();
                set_tick(rp);
            end
            if ($urandom_range(0, 9) == 0) begin
                div_ready = 1'b1;
                set_c(v64_t'({$urandom, $urandom}));
            end
            case (phase)
                0: begin
                    if (tick_valid) begin
                        if (!m_have) begin
                            m_prev = rp;
                            m_have = 1'b1;
                        end else if (has_zero(m_prev)) begin
                            m_prev = rp;
                            if (m_skip < 65535) m_skip++;
                        end else begin
                            e_a    = m_prev;
                            e_b    = rp;
                            e_sel  = cfg_sel;
                            m_pend = rp;
                            phase  = 1;
                        end
                    end
                end
                1: begin
                    div_ready = 1'b0;
                    n         = 0;
                    resp      = ($urandom_range(0, 15) == 0) ? 1000 : int'($urandom_range(1, 4));
                    phase     = 2;
                end
                2: begin
                    n++;
                    div_ready = 1'b0;
                    if (n == resp) begin
                        m_c       = v64_t'({$urandom, $urandom});
                        div_ready = 1'b1;
                        set_c(m_c);
                        m_prev    = m_pend;
                        phase     = 3;
                    end else if (n == TMO) begin
                        m_prev = m_pend;
                        m_err  = 1'b1;
                        phase  = 0;
                    end
                end
                default: begin
                    ret_ready = 1'($urandom);
                    if (ret_ready) phase = 0;
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
